// File: rtl/bcd_disp_if.sv
// Valid/ready input channel for bcd_disp_loader: binary value plus its
// leading-zero blanking request.
`timescale 1ns/1ps
interface bcd_disp_if #(
  parameter int BIN_W = 27
);
  logic [BIN_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_blank_lz;

  modport master (output in_data, output in_valid, output in_blank_lz, input in_ready);
  modport slave  (input in_data, input in_valid, input in_blank_lz, output in_ready);
endinterface

// File: rtl/bcd_disp_loader.sv
// Binary-to-BCD loader for an 8-digit 7-segment scanner: sequential double-dabble
// conversion into a double-buffered display register with blanking and overflow marking.
`timescale 1ns/1ps
module bcd_disp_loader #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic                       clk,
  input  logic                       rst,
  bcd_disp_if.slave                  in_if,
  input  logic [$clog2(DIGITS)-1:0]  rd_sel,
  output logic [3:0]                 rd_digit,
  output logic                       rd_blank,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf
);
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [W-1:0] add3(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   nib;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = v[4*i +: 4];
      r[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] lz_flags(input logic [W-1:0] v, input logic en);
    logic [DIGITS-1:0] f;
    logic              zero_run;
    f        = '0;
    zero_run = en;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (v[4*i +: 4] == 4'd0);
      f[i]     = zero_run;
    end
    return f;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, LOAD = 2'd2} state_t;

  state_t            state_r;
  logic [BIN_W-1:0]  bin_r;
  logic [W-1:0]      bcd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              lz_r;
  logic              ovf_pend_r;
  logic [W-1:0]      disp_r;
  logic [DIGITS-1:0] blank_r;
  logic              ovf_r;
  logic              done_r;
  logic              ready_r;
  logic              busy_r;
  logic [W-1:0]      adj_s;
  logic [W-1:0]      step_bcd_s;

  // One double-dabble step on the working register.
  always_comb begin
    adj_s      = add3(bcd_r);
    step_bcd_s = {adj_s[W-2:0], bin_r[BIN_W-1]};
  end

  // Control FSM, conversion datapath and display buffer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      bin_r      <= '0;
      bcd_r      <= '0;
      cnt_r      <= '0;
      lz_r       <= 1'b0;
      ovf_pend_r <= 1'b0;
      disp_r     <= '0;
      blank_r    <= '0;
      ovf_r      <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (in_if.in_valid && ready_r) begin
            bin_r      <= in_if.in_data;
            lz_r       <= in_if.in_blank_lz;
            ovf_pend_r <= ({{(64-BIN_W){1'b0}}, in_if.in_data} > MAX_VAL);
            bcd_r      <= '0;
            cnt_r      <= CNT_W'(BIN_W);
            state_r    <= CONV;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        CONV: begin
          done_r <= 1'b0;
          bcd_r  <= step_bcd_s;
          bin_r  <= {bin_r[BIN_W-2:0], 1'b0};
          cnt_r  <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          // Overflowed values are shown as a full row of 'E' with no blanking.
          if (ovf_pend_r) begin
            disp_r  <= {DIGITS{4'hE}};
            blank_r <= '0;
            ovf_r   <= 1'b1;
          end else begin
            disp_r  <= bcd_r;
            blank_r <= lz_flags(bcd_r, lz_r);
            ovf_r   <= 1'b0;
          end
          done_r  <= 1'b1;
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Scanner read port; indices beyond the digit count read as a dark zero.
  always_comb begin
    rd_digit = 4'd0;
    rd_blank = 1'b1;
    if (int'(rd_sel) < DIGITS) begin
      rd_digit = disp_r[4*int'(rd_sel) +: 4];
      rd_blank = blank_r[rd_sel];
    end else begin
      rd_digit = 4'd0;
      rd_blank = 1'b1;
    end
  end

  assign in_if.in_ready = ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign ovf            = ovf_r;
endmodule

// File: tb/tb_bcd_disp_loader.sv
// Directed scoreboard bench for bcd_disp_loader: expected displays are queued
// at acceptance and compared against the read port when done pulses.
`timescale 1ns/1ps
module tb_bcd_disp_loader;
  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rd_sel;
  logic [3:0] rd_digit;
  logic       rd_blank, busy, done, ovf;
  int         tests = 0;
  int         fails = 0;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  blk;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  bcd_disp_if #(.BIN_W(BIN_W)) bus ();

  bcd_disp_loader #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .in_if    (bus),
    .rd_sel   (rd_sel),
    .rd_digit (rd_digit),
    .rd_blank (rd_blank),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, blanking by magnitude comparison.
  task automatic expect_val(input int unsigned v, input logic lz);
    exp_t        e;
    int unsigned t, p;
    e = '0;
    if (v > 32'd99999999) begin
      e.dig = 32'hEEEEEEEE;
      e.blk = 8'h00;
      e.ovf = 1'b1;
    end else begin
      t = v;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
        e.dig[4*i +: 4] = 4'(t % 10);
        t = t / 10;
        if (i > 0) e.blk[i] = lz && (v < p);
        p = p * 10;
      end
    end
    sb.push_back(e);
  endtask

  task automatic send(input int unsigned v, input logic lz, input logic hold);
    @(negedge clk);
    bus.in_data     = BIN_W'(v);
    bus.in_blank_lz = lz;
    bus.in_valid    = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (bus.in_ready) break;
      @(negedge clk);
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    expect_val(v, lz);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd28);
    check({tag, "_ready_at_done"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_buf(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = DIGITS - 1; i >= 0; i--) begin
        rd_sel = 3'(i);
        #0.1;
        check($sformatf("%s_dig%0d", tag, i), 32'(rd_digit), 32'(e.dig[4*i +: 4]));
        check($sformatf("%s_blk%0d", tag, i), 32'(rd_blank), 32'(e.blk[i]));
      end
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  initial begin
    logic saw_done;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_blank_lz = 1'b0;
    rd_sel          = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    expect_val(0, 1'b0);
    check_buf("rst");

    send(12345678, 1'b0, 1'b0);
    check("conv_busy", 32'(busy), 32'd1);
    check("conv_ready", 32'(bus.in_ready), 32'd0);
    wait_done("v12345678");
    check_buf("v12345678");
    @(posedge clk);
    #1;
    check("done_pulse_width", 32'(done), 32'd0);

    send(42, 1'b1, 1'b0);
    wait_done("v42");
    check_buf("v42");

    send(0, 1'b1, 1'b0);
    wait_done("v0");
    check_buf("v0");

    send(100000000, 1'b1, 1'b0);
    wait_done("ovf");
    check_buf("ovf");

    send(7, 1'b0, 1'b0);
    wait_done("v7");
    check_buf("v7");

    // Valid held high; the value offered while busy must be ignored.
    send(5, 1'b0, 1'b1);
    bus.in_data = BIN_W'(9);
    wait_done("b2b_first");
    check_buf("b2b_first");
    @(posedge clk);
    expect_val(9, 1'b0);
    #1;
    bus.in_valid = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done("b2b_second");
    check_buf("b2b_second");

    // Reset during a conversion aborts it and clears the display.
    send(99999999, 1'b0, 1'b0);
    sb.delete();
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    expect_val(0, 1'b0);
    check_buf("abort");
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    expect_val(0, 1'b0);
    check_buf("abort_after");

    send(321, 1'b0, 1'b0);
    wait_done("v321");
    check_buf("v321");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
